// File: rtl/spi_cmd_pkg.sv
// Shared widths, frame layout, command codes and FSM encoding for the SPI command link.
package spi_cmd_pkg;

  localparam int unsigned LEN_SPI      = 32;
  localparam int unsigned SPI_CODE_LEN = 6;
  localparam int unsigned SPI_ADDR_LEN = 10;
  localparam int unsigned SPI_DATA_LEN = 16;
  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned CNT_W        = 6;

  localparam int unsigned CODE_LSB = 26;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [SPI_CODE_LEN-1:0] CMD_NOP       = 6'd0;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RESET     = 6'd1;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ID     = 6'd2;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_STATUS = 6'd3;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_CTRL   = 6'd4;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_CTRL   = 6'd5;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_MASK   = 6'd6;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_MASK   = 6'd7;
  localparam logic [SPI_CODE_LEN-1:0] CMD_SEL_CH    = 6'd8;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_GAIN   = 6'd9;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_ELEC   = 6'd10;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ELEC   = 6'd11;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_STIM   = 6'd12;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_STIM   = 6'd13;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_DAC    = 6'd14;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_DAC    = 6'd15;
  localparam logic [SPI_CODE_LEN-1:0] CMD_START     = 6'd16;
  localparam logic [SPI_CODE_LEN-1:0] CMD_STOP      = 6'd17;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_ADC    = 6'd18;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC    = 6'd19;
  localparam logic [SPI_CODE_LEN-1:0] CMD_ARM       = 6'd20;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_FIFO   = 6'd21;
  localparam logic [SPI_CODE_LEN-1:0] CMD_CLR_FIFO  = 6'd22;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_TRIG   = 6'd23;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_TRIG   = 6'd24;

  typedef struct packed {
    logic [SPI_CODE_LEN-1:0] code;
    logic [SPI_ADDR_LEN-1:0] addr;
    logic [SPI_DATA_LEN-1:0] data;
  } spi_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser with one extra flop for rise/fall strobes.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= STAGES'({sync, d});
      prev <= sync[STAGES-1];
    end
  end

  assign q      = sync[STAGES-1];
  assign rise_c = sync[STAGES-1] & ~prev;
  assign fall_c = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/spi_cmd_slave.sv
// Oversampled SPI mode-3 responder: deserialises 32-bit LSB-first command frames, returns a preloaded response word.
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int unsigned LEN_SPI      = spi_cmd_pkg::LEN_SPI,
  parameter int unsigned SPI_CODE_LEN = spi_cmd_pkg::SPI_CODE_LEN,
  parameter int unsigned SPI_ADDR_LEN = spi_cmd_pkg::SPI_ADDR_LEN,
  parameter int unsigned SPI_DATA_LEN = spi_cmd_pkg::SPI_DATA_LEN,
  parameter int unsigned SYNC_STAGES  = spi_cmd_pkg::SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sck,
  input  logic                    mosi,
  input  logic                    cs_n,
  output logic                    miso,
  output logic                    cmd_valid,
  output logic [SPI_CODE_LEN-1:0] cmd_code,
  output logic [SPI_ADDR_LEN-1:0] cmd_addr,
  output logic [SPI_DATA_LEN-1:0] cmd_data,
  output logic                    frame_err,
  input  logic [LEN_SPI-1:0]      rsp_data,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  output logic                    busy
);

  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s), .rise_c(sck_rise), .fall_c(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  logic unused;
  assign unused = ^{sck_s, sck_fall, mosi_rise, mosi_fall, cs_s};

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [LEN_SPI-1:0] rx_shift, tx_shift, tx_buf;
  spi_frame_t       cmd_q;
  logic             cmd_valid_q, frame_err_q;
  logic             cs_pend;   // cs_fall seen in DONE, replayed in IDLE
  logic             run;       // holds rsp_ready low while in reset
  logic             load;

  assign rsp_ready = run && (state == ST_IDLE) && !cs_fall && !cs_pend;
  assign load      = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cs_pend     <= 1'b0;
      run         <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      run         <= 1'b1;
      if (load) tx_buf <= rsp_data;
      case (state)
        ST_IDLE: begin
          tx_shift <= tx_buf;
          if (cs_fall || cs_pend) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            cs_pend <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            rx_shift <= {mosi_s, rx_shift[LEN_SPI-1:1]};
            tx_shift <= {1'b0, tx_shift[LEN_SPI-1:1]};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (cs_rise) state <= ST_DONE;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          cs_pend <= cs_fall;
          if (bit_cnt == CNT_W'(LEN_SPI)) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= spi_frame_t'(rx_shift);
            tx_buf      <= '0;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign miso      = tx_shift[0];
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_code  = cmd_q.code;
  assign cmd_addr  = cmd_q.addr;
  assign cmd_data  = cmd_q.data;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Scoreboard bench for spi_cmd_slave: bit-banged mode-3 host, decoded commands and miso words checked.
module tb_spi_cmd_slave;
  import spi_cmd_pkg::*;

  logic        clk, rst_n, sck, mosi, cs_n, miso;
  logic        cmd_valid, frame_err, rsp_valid, rsp_ready, busy;
  logic [5:0]  cmd_code;
  logic [9:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [31:0] rsp_data;

  spi_cmd_slave dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_err(frame_err), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  spi_frame_t  exp_q[$];
  spi_frame_t  got_q[$];
  int          ferr_cnt = 0;
  int          accept_cnt = 0;
  int          accept_busy_cnt = 0;
  int          bad_ready = 0;
  logic [31:0] last_accept = '0;
  time         cv_time = 0;
  time         accept_time = 0;

  // Output monitor away from the active edge
  always @(negedge clk) begin
    if (cmd_valid) begin
      got_q.push_back(spi_frame_t'({cmd_code, cmd_addr, cmd_data}));
      cv_time = $time;
    end
    if (frame_err) ferr_cnt++;
    if (rsp_ready && busy) bad_ready++;
  end

  // Handshake observed at the edge where it takes effect
  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) begin
      accept_cnt++;
      if (busy) accept_busy_cnt++;
      last_accept = rsp_data;
      accept_time = $time;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input int rsp_at,
                          input logic [31:0] rsp_word, input bit keep_cs, output logic [31:0] rx);
    rx   = '0;
    mosi = word[0];
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rsp_at) begin
        rsp_data  = rsp_word;
        rsp_valid = 1'b1;
      end
      sck = 1'b0;
      repeat (5) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (2) @(negedge clk);
      if (i + 1 < 32) mosi = word[i+1];
      repeat (3) @(negedge clk);
    end
    if (!keep_cs) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic load_rsp(input logic [31:0] word);
    int a0;
    a0 = accept_cnt;
    rsp_data  = word;
    rsp_valid = 1'b1;
    for (int k = 0; k < 20 && accept_cnt == a0; k++) @(negedge clk);
    rsp_valid = 1'b0;
    compared++;
    if (accept_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL load_accept: accepts=%0d required=1", accept_cnt - a0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({miso, cmd_valid, frame_err, busy, rsp_ready} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: {miso,cv,ferr,busy,ready}=%b required=00000",
               {miso, cmd_valid, frame_err, busy, rsp_ready});
    end
    compared++;
    if ({cmd_code, cmd_addr, cmd_data} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_fields: got=%h required=00000000", {cmd_code, cmd_addr, cmd_data});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (rsp_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: rsp_ready=%b required=1", rsp_ready);
    end
  endtask

  task automatic test_decode();
    logic [31:0] words [2];
    int          ecode [2];
    int          eaddr [2];
    logic [31:0] rx;
    spi_frame_t  e, g;
    int          f0;
    words = '{32'h2004_0000, 32'h4C0B_0000};
    ecode = '{8, 19};
    eaddr = '{4, 11};
    f0 = ferr_cnt;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(spi_frame_t'{code: 6'(ecode[i]), addr: 10'(eaddr[i]), data: 16'h0});
      spi_xfer(words[i], 32, -1, '0, 1'b0, rx);
      compared++;
      if (got_q.size() !== 1) begin
        mismatched++;
        $display("FAIL decode_count[%0d]: strobes=%0d required=1", i, got_q.size());
        got_q.delete();
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        compared++;
        if (g.code !== e.code) begin
          mismatched++;
          $display("FAIL decode_code[%0d]: got=%0d required=%0d", i, g.code, e.code);
        end
        compared++;
        if (g.addr !== e.addr) begin
          mismatched++;
          $display("FAIL decode_addr[%0d]: got=%h required=%h", i, g.addr, e.addr);
        end
        compared++;
        if (g.data !== e.data) begin
          mismatched++;
          $display("FAIL decode_data[%0d]: got=%h required=%h", i, g.data, e.data);
        end
      end
    end
    compared++;
    if (ferr_cnt !== f0) begin
      mismatched++;
      $display("FAIL decode_ferr: frame_err pulses=%0d required=0", ferr_cnt - f0);
    end
  endtask

  task automatic test_response();
    logic [31:0] exp_rx [$];
    logic [31:0] rx, e;
    load_rsp(32'hA5A5_1234);
    exp_rx.push_back(32'hA5A5_1234);
    exp_rx.push_back(32'h0);
    for (int i = 0; i < 2; i++) begin
      spi_xfer(32'h2004_0000, 32, -1, '0, 1'b0, rx);
      e = exp_rx.pop_front();
      compared++;
      if (rx !== e) begin
        mismatched++;
        $display("FAIL response_miso[%0d]: got=%h required=%h", i, rx, e);
      end
    end
    compared++;
    if (got_q.size() !== 2) begin
      mismatched++;
      $display("FAIL response_strobes: got=%0d required=2", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_short_frame();
    logic [31:0] rx;
    spi_frame_t  e, g;
    int          f0;
    load_rsp(32'h1357_9BDF);
    f0 = ferr_cnt;
    spi_xfer(32'h4C0B_0000, 20, -1, '0, 1'b0, rx);
    compared++;
    if (ferr_cnt - f0 !== 1) begin
      mismatched++;
      $display("FAIL short_ferr: pulses=%0d required=1", ferr_cnt - f0);
    end
    compared++;
    if (got_q.size() !== 0) begin
      mismatched++;
      $display("FAIL short_no_cmd: strobes=%0d required=0", got_q.size());
      got_q.delete();
    end
    compared++;
    if (cmd_code !== 6'd8) begin
      mismatched++;
      $display("FAIL short_hold_code: got=%0d required=8", cmd_code);
    end
    compared++;
    if (rx[19:0] !== 20'h79BDF) begin
      mismatched++;
      $display("FAIL short_miso: got=%h required=79bdf", rx[19:0]);
    end
    exp_q.push_back(spi_frame_t'{code: 6'd19, addr: 10'h00B, data: 16'h0});
    spi_xfer(32'h4C0B_0000, 32, -1, '0, 1'b0, rx);
    compared++;
    if (rx !== 32'h1357_9BDF) begin
      mismatched++;
      $display("FAIL short_txbuf_kept: got=%h required=13579bdf", rx);
    end
    compared++;
    if (got_q.size() !== 1) begin
      mismatched++;
      $display("FAIL short_next_count: strobes=%0d required=1", got_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL short_next_decode: got=%h required=%h", g, e);
      end
    end
    compared++;
    if (ferr_cnt - f0 !== 1) begin
      mismatched++;
      $display("FAIL short_next_ferr: pulses=%0d required=1", ferr_cnt - f0);
    end
  endtask

  task automatic test_rsp_hold();
    logic [31:0] rx, rx2;
    int          a0, ab0, br0;
    a0  = accept_cnt;
    ab0 = accept_busy_cnt;
    br0 = bad_ready;
    fork
      spi_xfer(32'h2004_0000, 32, 4, 32'hCAFE_F00D, 1'b0, rx);
      begin
        for (int k = 0; k < 2000 && accept_cnt == a0; k++) @(negedge clk);
        rsp_valid = 1'b0;
      end
    join
    compared++;
    if (accept_cnt - a0 !== 1) begin
      mismatched++;
      $display("FAIL hold_accepts: got=%0d required=1", accept_cnt - a0);
    end
    compared++;
    if (accept_busy_cnt !== ab0 || bad_ready !== br0) begin
      mismatched++;
      $display("FAIL hold_busy: busy accepts=%0d ready-while-busy=%0d required=0/0",
               accept_busy_cnt - ab0, bad_ready - br0);
    end
    compared++;
    if (accept_time !== cv_time + 10) begin
      mismatched++;
      $display("FAIL hold_first_idle: accept at %0t required %0t", accept_time, cv_time + 10);
    end
    compared++;
    if (rx !== 32'h0) begin
      mismatched++;
      $display("FAIL hold_miso_during: got=%h required=00000000", rx);
    end
    spi_xfer(32'h2004_0000, 32, -1, '0, 1'b0, rx2);
    compared++;
    if (rx2 !== 32'hCAFE_F00D || last_accept !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL hold_miso_next: got=%h accepted=%h required=cafef00d", rx2, last_accept);
    end
    got_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    int          f0;
    spi_frame_t  g;
    spi_xfer(32'h4C0B_0000, 12, -1, '0, 1'b1, rx);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({miso, cmd_valid, frame_err, busy, rsp_ready} !== 5'b0 ||
        {cmd_code, cmd_addr, cmd_data} !== 32'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: ctrl=%b fields=%h required=00000/00000000",
               {miso, cmd_valid, frame_err, busy, rsp_ready}, {cmd_code, cmd_addr, cmd_data});
    end
    cs_n = 1'b1; sck = 1'b1; mosi = 1'b0;
    f0 = ferr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    compared++;
    if (ferr_cnt !== f0 || got_q.size() !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_quiet: ferr=%0d cmds=%0d busy=%b required=0/0/0",
               ferr_cnt - f0, got_q.size(), busy);
      got_q.delete();
    end
    exp_q.push_back(spi_frame_t'{code: 6'd20, addr: 10'h0, data: 16'h0});
    spi_xfer(32'h5000_0000, 32, -1, '0, 1'b0, rx);
    compared++;
    if (got_q.size() !== 1) begin
      mismatched++;
      $display("FAIL midreset_next_count: strobes=%0d required=1", got_q.size());
    end else begin
      g = got_q.pop_front();
      compared++;
      if (g !== exp_q[0]) begin
        mismatched++;
        $display("FAIL midreset_next_decode: got=%h required=%h", g, exp_q[0]);
      end
    end
    exp_q.delete();
    compared++;
    if (rx !== 32'h0) begin
      mismatched++;
      $display("FAIL midreset_miso: got=%h required=00000000", rx);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_response();
    test_short_frame();
    test_rsp_hold();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
